// File: rtl/kb_scan.sv
// Keypad row-scan initiator: walks the rows, waits for the debouncer to settle,
// and reports one legend-encoded key per debounced press.
module kb_scan #(
  parameter int BLANK   = 4,
  parameter int TIMEOUT = 150000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [3:0] row_scan,
  input  logic       kb_valid,
  input  logic [3:0] kb_row,
  input  logic [3:0] kb_col,
  input  logic       kb_debounce_ok,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_err,
  output logic       key_held
);

  localparam int CW = $clog2(((TIMEOUT > BLANK) ? TIMEOUT : BLANK) + 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] REL_LAST   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_BLANK, S_WAIT, S_CHECK, S_HOLD, S_REL, S_ADV
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    ridx, ridx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [3:0] row_scan_nxt, key_code_nxt;
  logic       key_valid_nxt, key_err_nxt, key_held_nxt;
  logic       accept;

  function automatic logic [3:0] encode(input logic [1:0] ri, input logic [3:0] col);
    logic [1:0] ci;
    logic [3:0] code;
    ci = 2'd0;
    case (col)
      4'b1110: ci = 2'd0;
      4'b1101: ci = 2'd1;
      4'b1011: ci = 2'd2;
      4'b0111: ci = 2'd3;
      default: ci = 2'd0;
    endcase
    case ({ri, ci})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // A press is only trusted when it is on the driven row and exactly one column is low.
  assign accept = (kb_row == row_scan) && ($countones(~kb_col) == 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ridx      <= 2'd0;
      cnt       <= '0;
      row_scan  <= 4'b1111;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ridx      <= ridx_nxt;
      cnt       <= cnt_nxt;
      row_scan  <= row_scan_nxt;
      key_code  <= key_code_nxt;
      key_valid <= key_valid_nxt;
      key_err   <= key_err_nxt;
      key_held  <= key_held_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ridx_nxt  = ridx;
    if (!en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_BLANK;
          ridx_nxt  = 2'd0;
        end
        S_BLANK: if (cnt == BLANK_LAST) state_nxt = S_WAIT;
        S_WAIT: begin
          if (kb_debounce_ok)      state_nxt = S_CHECK;
          else if (cnt == TO_LAST) state_nxt = S_ADV;
        end
        S_CHECK: state_nxt = kb_valid ? S_HOLD : S_ADV;
        S_HOLD:  if (!kb_debounce_ok) state_nxt = S_REL;
        S_REL: begin
          if (kb_valid)                                state_nxt = S_HOLD;
          else if (kb_debounce_ok && cnt == REL_LAST) state_nxt = S_ADV;
        end
        S_ADV: begin
          ridx_nxt  = ridx + 2'd1;
          state_nxt = S_BLANK;
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    // The counter restarts on every state change; in REL it counts consecutive clean cycles.
    cnt_nxt = cnt + CW'(1);
    if (state_nxt != state || state == S_IDLE || state == S_HOLD)
      cnt_nxt = '0;
    else if (state == S_REL && !(kb_debounce_ok && !kb_valid))
      cnt_nxt = '0;
  end

  always_comb begin
    row_scan_nxt  = (state_nxt == S_IDLE) ? 4'b1111 : ~(4'b0001 << ridx_nxt);
    key_valid_nxt = en && (state == S_CHECK) && kb_valid && accept;
    key_err_nxt   = en && (state == S_CHECK) && kb_valid && !accept;
    key_code_nxt  = key_valid_nxt ? encode(ridx, kb_col) : key_code;
    key_held_nxt  = key_held;
    if (!en)
      key_held_nxt = 1'b0;
    else if (state == S_CHECK && kb_valid)
      key_held_nxt = 1'b1;
    else if (state == S_REL && state_nxt == S_ADV)
      key_held_nxt = 1'b0;
  end

endmodule

// File: tb/tb_kb_scan.sv
// Directed bench for kb_scan: drives the debouncer outputs by hand and checks
// scan order, dwell times, key reporting, release handling, en and rst.
module tb_kb_scan;

  localparam int BLANK   = 4;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst, en;
  logic       kb_valid, kb_debounce_ok;
  logic [3:0] kb_row, kb_col;
  logic [3:0] row_scan, key_code;
  logic       key_valid, key_err, key_held;

  int checks = 0;
  int passed = 0;
  int n_valid = 0, n_err = 0, n_both = 0;
  int n;

  kb_scan #(.BLANK(BLANK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .row_scan(row_scan),
    .kb_valid(kb_valid), .kb_row(kb_row), .kb_col(kb_col),
    .kb_debounce_ok(kb_debounce_ok), .key_code(key_code),
    .key_valid(key_valid), .key_err(key_err), .key_held(key_held)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_valid) n_valid++;
    if (key_err) n_err++;
    if (key_valid && key_err) n_both++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic ok, input logic v, input logic [3:0] r, input logic [3:0] c);
    kb_debounce_ok = ok;
    kb_valid       = v;
    kb_row         = r;
    kb_col         = c;
  endtask

  task automatic waitRowChange(input logic [3:0] from, input int budget, output int cyc);
    cyc = 0;
    while (row_scan == from && cyc < budget) begin
      cyc++;
      step();
    end
  endtask

  task automatic waitPulse(input int budget);
    int c;
    c = 0;
    while (!(key_valid || key_err) && c < budget) begin
      c++;
      step();
    end
    checkOutput("pulse_seen", c < budget, 1);
  endtask

  logic [3:0] rows [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
    repeat (3) step();
    checkOutput("rst_row", row_scan, 4'hF);
    checkOutput("rst_code", key_code, 4'h0);
    checkOutput("rst_valid", key_valid, 0);
    checkOutput("rst_err", key_err, 0);
    checkOutput("rst_held", key_held, 0);
    rst = 1'b0;
    step();
    checkOutput("idle_row", row_scan, 4'hF);

    // Idle scan: debounce_ok always high, no key; each row lasts BLANK+3 cycles
    applyStimulus(1'b1, 1'b0, 4'hF, 4'hF);
    en = 1'b1;
    step();
    checkOutput("scan_start", row_scan, 4'b1110);
    for (int i = 0; i < 4; i++) begin
      waitRowChange(rows[i], 50, n);
      checkOutput($sformatf("dwell_%0d", i), n, BLANK + 3);
      checkOutput($sformatf("next_row_%0d", i), row_scan, rows[i+1]);
    end
    checkOutput("scan_no_valid", n_valid, 0);
    checkOutput("scan_no_err", n_err, 0);

    // r1/c2 with bouncing before the debouncer settles
    waitRowChange(4'b1110, 50, n);
    checkOutput("r1_row", row_scan, 4'b1101);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, i[0], 4'b1101, i[0] ? 4'b1011 : 4'b1001);
      step();
    end
    applyStimulus(1'b1, 1'b1, 4'b1101, 4'b1011);
    waitPulse(20);
    checkOutput("r1_valid", key_valid, 1);
    checkOutput("r1_code", key_code, 4'h6);
    repeat (20) step();
    checkOutput("r1_hold_row", row_scan, 4'b1101);
    checkOutput("r1_hold_held", key_held, 1);
    checkOutput("r1_nvalid", n_valid, 1);
    checkOutput("r1_nerr", n_err, 0);
    applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
    repeat (3) step();
    checkOutput("r1_rel_row", row_scan, 4'b1101);
    checkOutput("r1_rel_held", key_held, 1);
    applyStimulus(1'b1, 1'b0, 4'hF, 4'hF);
    waitRowChange(4'b1101, 20, n);
    checkOutput("r1_after_row", row_scan, 4'b1011);
    checkOutput("r1_after_held", key_held, 0);

    // Two keys on r3: rejected with key_err
    waitRowChange(4'b1011, 30, n);
    checkOutput("r3_row", row_scan, 4'b0111);
    applyStimulus(1'b1, 1'b1, 4'b0111, 4'b1010);
    waitPulse(30);
    checkOutput("multi_err", key_err, 1);
    checkOutput("multi_no_valid", key_valid, 0);
    repeat (10) step();
    checkOutput("multi_held", key_held, 1);
    checkOutput("multi_row", row_scan, 4'b0111);
    checkOutput("multi_nerr", n_err, 1);
    checkOutput("multi_nvalid", n_valid, 1);
    checkOutput("multi_code_kept", key_code, 4'h6);
    applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
    step();
    applyStimulus(1'b1, 1'b0, 4'hF, 4'hF);
    waitRowChange(4'b0111, 20, n);
    checkOutput("multi_resume_row", row_scan, 4'b1110);
    checkOutput("multi_resume_held", key_held, 0);

    // r0/c3 with a bounce back during release
    applyStimulus(1'b1, 1'b1, 4'b1110, 4'b0111);
    waitPulse(30);
    checkOutput("a_valid", key_valid, 1);
    checkOutput("a_code", key_code, 4'hA);
    repeat (5) step();
    applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
    step();
    applyStimulus(1'b1, 1'b0, 4'hF, 4'hF);
    step();
    applyStimulus(1'b1, 1'b1, 4'b1110, 4'b0111);
    step();
    applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
    step();
    step();
    checkOutput("a_bounce_held", key_held, 1);
    checkOutput("a_bounce_row", row_scan, 4'b1110);
    checkOutput("a_bounce_nvalid", n_valid, 2);
    applyStimulus(1'b1, 1'b0, 4'hF, 4'hF);
    waitRowChange(4'b1110, 20, n);
    checkOutput("a_after_row", row_scan, 4'b1101);
    checkOutput("a_after_held", key_held, 0);
    checkOutput("a_after_nvalid", n_valid, 2);

    // debounce_ok stuck low on r2: timeout advances the row silently
    waitRowChange(4'b1101, 30, n);
    checkOutput("to_row", row_scan, 4'b1011);
    applyStimulus(1'b0, 1'b0, 4'hF, 4'hF);
    waitRowChange(4'b1011, 300, n);
    checkOutput("to_dwell", n, BLANK + TIMEOUT + 1);
    checkOutput("to_next_row", row_scan, 4'b0111);
    checkOutput("to_nvalid", n_valid, 2);
    checkOutput("to_nerr", n_err, 1);

    // en dropped while holding r3/c0
    applyStimulus(1'b1, 1'b1, 4'b0111, 4'b1110);
    waitPulse(30);
    checkOutput("e_code", key_code, 4'hE);
    repeat (4) step();
    checkOutput("e_held_before", key_held, 1);
    en = 1'b0;
    step();
    checkOutput("en_off_row", row_scan, 4'hF);
    checkOutput("en_off_held", key_held, 0);
    checkOutput("en_off_code_kept", key_code, 4'hE);
    repeat (5) step();
    checkOutput("en_off_idle_row", row_scan, 4'hF);
    checkOutput("en_off_nvalid", n_valid, 3);
    en = 1'b1;
    step();
    checkOutput("en_on_row", row_scan, 4'b1110);

    // rst while in CHECK with a valid r0/c1 press pending
    applyStimulus(1'b1, 1'b1, 4'b1110, 4'b1101);
    repeat (BLANK + 1) step();
    checkOutput("chk_no_pulse_yet", key_valid, 0);
    rst = 1'b1;
    step();
    checkOutput("rst2_row", row_scan, 4'hF);
    checkOutput("rst2_code", key_code, 4'h0);
    checkOutput("rst2_valid", key_valid, 0);
    checkOutput("rst2_err", key_err, 0);
    checkOutput("rst2_held", key_held, 0);
    checkOutput("rst2_nvalid", n_valid, 3);
    rst = 1'b0;
    step();

    checkOutput("never_both", n_both, 0);
    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
